// File: rtl/bcd_display_driver.sv
// Keypad digit capture buffer feeding a time-multiplexed 7-segment display.
// Digits shift in from the right; empty leading positions stay blank.
module bcd_display_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [3:0]                        bcd_in,
    input  logic                              bcd_valid,
    input  logic                              clear,
    output logic [6:0]                        seg,
    output logic [NUM_DIGITS-1:0]             digit_sel,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
    output logic                              full,
    output logic                              err
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0] BLANK = 4'hF;

    function automatic logic [6:0] seg_encode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return (SEG_ACTIVE_LOW != 0) ? ~s : s;
    endfunction

    logic [3:0]    digits [NUM_DIGITS];
    logic          valid_q;
    logic [PW-1:0] prescale;
    logic [IW-1:0] scan_idx;
    logic [IW-1:0] scan_idx_next;
    logic          key_edge;
    logic          bad_code;
    logic          scan_tc;

    assign key_edge = bcd_valid & ~valid_q;
    assign bad_code = (bcd_in > 4'd9);
    assign full     = (count == CW'(NUM_DIGITS));
    assign scan_tc  = (prescale == PW'(SCAN_DIV - 1));

    always_comb begin
        scan_idx_next = scan_idx;
        if (scan_tc) begin
            scan_idx_next = (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // valid_q starts high so a key held through reset is not taken as a new press
            valid_q   <= 1'b1;
            count     <= '0;
            err       <= 1'b0;
            prescale  <= '0;
            scan_idx  <= '0;
            digit_sel <= {{(NUM_DIGITS-1){1'b0}}, 1'b1};
            seg       <= seg_encode(BLANK);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits[i] <= BLANK;
            end
        end else begin
            valid_q <= bcd_valid;
            err     <= key_edge & ~clear & bad_code;

            // clear takes priority and swallows a simultaneous key edge
            if (clear) begin
                count <= '0;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    digits[i] <= BLANK;
                end
            end else if (key_edge && !bad_code && !full) begin
                count     <= count + 1'b1;
                digits[0] <= bcd_in;
                for (int i = 1; i < NUM_DIGITS; i++) begin
                    digits[i] <= digits[i-1];
                end
            end

            prescale  <= scan_tc ? '0 : prescale + 1'b1;
            scan_idx  <= scan_idx_next;
            // select and segments follow the upcoming index so they switch together
            digit_sel <= {{(NUM_DIGITS-1){1'b0}}, 1'b1} << scan_idx_next;
            seg       <= seg_encode(digits[scan_idx_next]);
        end
    end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver: capture table plus scan/reset sequences.
module tb_bcd_display_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] bcd_in;
    logic       bcd_valid;
    logic       clear;
    logic [6:0] seg;
    logic [3:0] digit_sel;
    logic [2:0] count;
    logic       full;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_display_driver #(
        .NUM_DIGITS(4),
        .SCAN_DIV(4),
        .SEG_ACTIVE_LOW(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bcd_in(bcd_in),
        .bcd_valid(bcd_valid),
        .clear(clear),
        .seg(seg),
        .digit_sel(digit_sel),
        .count(count),
        .full(full),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  b;
        logic        c;
        logic [2:0]  cnt;
        logic        fl;
        logic        er;
        logic        dchk;
        logic [27:0] disp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [3:0] b, input logic c,
                       input logic [2:0] cnt, input logic fl, input logic er,
                       input logic dchk = 1'b0, input logic [27:0] disp = 28'h0);
        vec_t r;
        r.v = v; r.b = b; r.c = c; r.cnt = cnt; r.fl = fl; r.er = er;
        r.dchk = dchk; r.disp = disp;
        vecs.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // exp packs the expected segments {pos3, pos2, pos1, pos0}
    task automatic check_disp(input logic [27:0] exp, input string nm);
        bit seen [4];
        for (int p = 0; p < 4; p++) seen[p] = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 24; k++) begin
            tick();
            chk({nm, " onehot"}, {31'b0, $onehot(digit_sel)}, 32'd1);
            for (int p = 0; p < 4; p++) begin
                if (digit_sel[p] && !seen[p]) begin
                    seen[p] = 1'b1;
                    chk($sformatf("%s seg pos%0d", nm, p), {25'b0, seg}, {25'b0, exp[7*p +: 7]});
                end
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (!seen[p]) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s scan: position %0d never selected, required within 24 cycles", nm, p);
            end
        end
    endtask

    initial begin
        reset = 1'b1; bcd_in = 4'd0; bcd_valid = 1'b0; clear = 1'b0;

        // Test 1: reset state and scan timing
        tick(); tick();
        reset = 1'b0;
        chk("rst seg", {25'b0, seg}, 32'h00);
        chk("rst digit_sel", {28'b0, digit_sel}, 32'h1);
        chk("rst count", {29'b0, count}, 32'd0);
        chk("rst full", {31'b0, full}, 32'd0);
        chk("rst err", {31'b0, err}, 32'd0);
        repeat (3) tick();
        chk("scan hold 3", {28'b0, digit_sel}, 32'h1);
        tick();
        chk("scan step 4", {28'b0, digit_sel}, 32'h2);
        repeat (4) tick();
        chk("scan step 8", {28'b0, digit_sel}, 32'h4);
        repeat (4) tick();
        chk("scan step 12", {28'b0, digit_sel}, 32'h8);
        repeat (4) tick();
        chk("scan wrap 16", {28'b0, digit_sel}, 32'h1);

        // Test 2: enter 1,2,3
        add(1, 4'd1, 0, 1, 0, 0); add(0, 4'd1, 0, 1, 0, 0);
        add(1, 4'd2, 0, 2, 0, 0); add(0, 4'd2, 0, 2, 0, 0);
        add(1, 4'd3, 0, 3, 0, 0);
        add(0, 4'd3, 0, 3, 0, 0, 1, {7'h00, 7'h06, 7'h5B, 7'h4F});
        // Test 3: fill with 9,8,7,6 then drop 5
        add(0, 4'd0, 1, 0, 0, 0);
        add(1, 4'd9, 0, 1, 0, 0); add(0, 4'd9, 0, 1, 0, 0);
        add(1, 4'd8, 0, 2, 0, 0); add(0, 4'd8, 0, 2, 0, 0);
        add(1, 4'd7, 0, 3, 0, 0); add(0, 4'd7, 0, 3, 0, 0);
        add(1, 4'd6, 0, 4, 1, 0); add(0, 4'd6, 0, 4, 1, 0);
        add(1, 4'd5, 0, 4, 1, 0);
        add(0, 4'd5, 0, 4, 1, 0, 1, {7'h6F, 7'h7F, 7'h07, 7'h7D});
        // Test 4: held key captures once, then an invalid code
        add(0, 4'd0, 1, 0, 0, 0);
        add(1, 4'd2, 0, 1, 0, 0); add(0, 4'd2, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) add(1, 4'd4, 0, 2, 0, 0);
        add(0, 4'd4, 0, 2, 0, 0);
        add(1, 4'hA, 0, 2, 0, 1);
        add(1, 4'hA, 0, 2, 0, 0);
        add(0, 4'd0, 0, 2, 0, 0, 1, {7'h00, 7'h00, 7'h5B, 7'h66});
        // Test 5: clear coincident with a key edge
        add(1, 4'd5, 0, 3, 0, 0); add(0, 4'd5, 0, 3, 0, 0);
        add(1, 4'd7, 1, 0, 0, 0);
        add(0, 4'd7, 0, 0, 0, 0, 1, 28'h0);
        add(1, 4'd8, 0, 1, 0, 0);
        add(0, 4'd8, 0, 1, 0, 0, 1, {7'h00, 7'h00, 7'h00, 7'h7F});

        for (int i = 0; i < vecs.size(); i++) begin
            bcd_valid = vecs[i].v;
            bcd_in    = vecs[i].b;
            clear     = vecs[i].c;
            tick();
            chk($sformatf("vec%0d count", i), {29'b0, count}, {29'b0, vecs[i].cnt});
            chk($sformatf("vec%0d full", i), {31'b0, full}, {31'b0, vecs[i].fl});
            chk($sformatf("vec%0d err", i), {31'b0, err}, {31'b0, vecs[i].er});
            if (vecs[i].dchk) begin
                bcd_valid = 1'b0;
                clear     = 1'b0;
                check_disp(vecs[i].disp, $sformatf("vec%0d disp", i));
            end
        end

        // Test 6: key held across a mid-scan reset
        bcd_valid = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0; bcd_in = 4'd3; bcd_valid = 1'b1;
        tick();
        chk("t6 pre-reset count", {29'b0, count}, 32'd1);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("t6 rst count", {29'b0, count}, 32'd0);
        chk("t6 rst full", {31'b0, full}, 32'd0);
        chk("t6 rst err", {31'b0, err}, 32'd0);
        chk("t6 rst digit_sel", {28'b0, digit_sel}, 32'h1);
        chk("t6 rst seg", {25'b0, seg}, 32'h00);
        reset = 1'b0;
        repeat (3) tick();
        chk("t6 scan hold", {28'b0, digit_sel}, 32'h1);
        chk("t6 held no capture", {29'b0, count}, 32'd0);
        tick();
        chk("t6 scan step", {28'b0, digit_sel}, 32'h2);
        repeat (4) tick();
        chk("t6 still held", {29'b0, count}, 32'd0);
        bcd_valid = 1'b0;
        tick();
        bcd_valid = 1'b1;
        tick();
        chk("t6 re-press capture", {29'b0, count}, 32'd1);
        bcd_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
